// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 bus driver.
//   - lcd_state_e : FSM state encoding
//   - init_rom()  : power-on instruction sequence (INIT_LEN entries)
//   - CLEAR/HOME opcodes and default timing constants (cycles @ 20 MHz)
//   - phase_load(): converts a phase length N into the counter preload value
package lcd_pkg;

  localparam int CNT_W    = 19;
  localparam int INIT_LEN = 6;

  localparam int unsigned DEF_T_POWERUP = 300000;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_EN      = 6;
  localparam int unsigned DEF_T_HOLD    = 2;
  localparam int unsigned DEF_T_EXEC    = 800;
  localparam int unsigned DEF_T_CLEAR   = 33000;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h38;
      3'd2:    return 8'h38;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      3'd5:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // The counter runs N-1 .. 0, so a phase of N cycles preloads N-1.
  // Lengths of 0 collapse to a single cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned n);
    if (n <= 1) return '0;
    return CNT_W'(n - 1);
  endfunction

  // Clear and home need the long execution wait; data bytes never do.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == OP_CLEAR) || (b == OP_HOME) || (b == OP_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: single down-counter timing every FSM phase.
// Ports:
//   clk_20m  in  system clock
//   rst      in  synchronous active-low reset (reloads RESET_VAL)
//   load     in  preload load_val this edge
//   load_val in  preload value (phase length - 1)
//   done     out 1 while the count sits at zero (last cycle of a phase)
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk_20m,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an unattended counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_20m) begin
    if (!rst) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: drives an HD44780-compatible 8-bit LCD bus from a
// valid/ready request interface and runs the power-on init sequence.
// Ports:
//   clk_20m    in   system clock, 20 MHz
//   rst        in   synchronous active-low reset
//   wr / dbi   in   data write request (level) and data byte
//   dr / direc in   instruction write request (level) and instruction byte
//   ready      out  idle; a request present this cycle is accepted
//   init_done  out  power-on sequence complete (sticky until reset)
//   lcd_rs     out  0 = instruction, 1 = data
//   lcd_rw     out  tied 0 (write only)
//   lcd_e      out  enable strobe
//   lcd_db     out  LCD data bus (holds last byte when idle)
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = DEF_T_POWERUP,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_EN      = DEF_T_EN,
  parameter int unsigned T_HOLD    = DEF_T_HOLD,
  parameter int unsigned T_EXEC    = DEF_T_EXEC,
  parameter int unsigned T_CLEAR   = DEF_T_CLEAR
) (
  input  logic       clk_20m,
  input  logic       rst,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] dbi,
  input  logic [7:0] direc,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  localparam logic [CNT_W-1:0] LD_POWERUP = phase_load(T_POWERUP);
  localparam logic [CNT_W-1:0] LD_SETUP   = phase_load(T_SETUP);
  localparam logic [CNT_W-1:0] LD_EN      = phase_load(T_EN);
  localparam logic [CNT_W-1:0] LD_HOLD    = phase_load(T_HOLD);
  localparam logic [CNT_W-1:0] LD_EXEC    = phase_load(T_EXEC);
  localparam logic [CNT_W-1:0] LD_CLEAR   = phase_load(T_CLEAR);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic [2:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;

  // Reset preloads the full power-up delay, so POWERUP needs no load.
  lcd_delay_counter #(
    .RESET_VAL(LD_POWERUP)
  ) u_delay (
    .clk_20m (clk_20m),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .done    (cnt_done)
  );

  always_ff @(posedge clk_20m) begin
    if (!rst) begin
      state_q     <= ST_POWERUP;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Each transition into a timed phase also preloads the counter for it.
  // INIT is a one-cycle dispatcher that feeds the next ROM entry into the
  // same SETUP..WAIT path used by host requests; init_done_q low means the
  // WAIT phase belongs to the init sequence.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    db_d         = db_q;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_done) begin
          idx_d   = 3'd0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        rs_d         = 1'b0;
        db_d         = init_rom(idx_q);
        cnt_load     = 1'b1;
        cnt_load_val = LD_SETUP;
        state_d      = ST_SETUP;
      end
      ST_IDLE: begin
        // Instruction wins a tie; a held wr is taken in the next window.
        if (dr) begin
          rs_d         = 1'b0;
          db_d         = direc;
          cnt_load     = 1'b1;
          cnt_load_val = LD_SETUP;
          state_d      = ST_SETUP;
        end else if (wr) begin
          rs_d         = 1'b1;
          db_d         = dbi;
          cnt_load     = 1'b1;
          cnt_load_val = LD_SETUP;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_load     = 1'b1;
          cnt_load_val = LD_EN;
          state_d      = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (cnt_done) begin
          cnt_load     = 1'b1;
          cnt_load_val = LD_HOLD;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          cnt_load     = 1'b1;
          cnt_load_val = is_long_cmd(rs_q, db_q) ? LD_CLEAR : LD_EXEC;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_comb begin
    ready     = (state_q == ST_IDLE);
    lcd_e     = (state_q == ST_ENABLE);
    lcd_rs    = rs_q;
    lcd_db    = db_q;
    lcd_rw    = 1'b0;
    init_done = init_done_q;
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: self-checking bench for lcd_bus_driver, run with short
// timing parameters so the full init sequence fits in a few hundred cycles.
module tb_lcd_bus_driver;

  localparam int P       = 40;
  localparam int S       = 2;
  localparam int E       = 6;
  localparam int H       = 2;
  localparam int X       = 30;
  localparam int C       = 100;
  localparam int BASE    = S + E + H;
  localparam int TIMEOUT = 3000;

  logic       clk_20m = 1'b0;
  logic       rst     = 1'b0;
  logic       wr      = 1'b0;
  logic       dr      = 1'b0;
  logic [7:0] dbi     = 8'h00;
  logic [7:0] direc   = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  always #5 clk_20m = ~clk_20m;

  lcd_bus_driver #(
    .T_POWERUP(P), .T_SETUP(S), .T_EN(E), .T_HOLD(H), .T_EXEC(X), .T_CLEAR(C)
  ) dut (
    .clk_20m  (clk_20m),
    .rst      (rst),
    .wr       (wr),
    .dr       (dr),
    .dbi      (dbi),
    .direc    (direc),
    .ready    (ready),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_db   (lcd_db)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] db;
  } strobe_t;

  typedef struct {
    string      name;
    logic       dr;
    logic       wr;
    logic [7:0] direc;
    logic [7:0] dbi;
    logic       exp_rs;
    logic [7:0] exp_db;
    int         exp_busy;
  } vec_t;

  int      compared   = 0;
  int      mismatched = 0;
  int      cyc        = 0;
  strobe_t strobes[$];
  int      busy_q[$];
  int      first_rise_cyc = -1;
  int      fall_cyc       = -1;
  int      rw_errors      = 0;
  int      glitch_errors  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Edge counter: at any point after edge n, cyc == n.
  initial forever begin
    @(posedge clk_20m);
    cyc++;
  end

  // Bus monitor: records each strobe, its width, and bus stability.
  initial begin
    logic    prev_e;
    int      width;
    strobe_t cur;
    prev_e = 1'b0;
    width  = 0;
    cur    = '0;
    forever begin
      @(negedge clk_20m);
      if (lcd_rw !== 1'b0) rw_errors++;
      if (lcd_e && !prev_e) begin
        cur.rs = lcd_rs;
        cur.db = lcd_db;
        strobes.push_back(cur);
        width = 1;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
      end else if (lcd_e) begin
        width++;
        if (rst && (lcd_rs !== cur.rs || lcd_db !== cur.db)) glitch_errors++;
      end else if (prev_e) begin
        fall_cyc = cyc;
        if (rst) checkOutput("e_width", width, E);
      end
      prev_e = lcd_e;
    end
  end

  task automatic waitReady(input string name, output int cycles);
    cycles = 0;
    while (!ready && cycles < TIMEOUT) begin
      @(posedge clk_20m);
      #1;
      cycles++;
    end
    checkOutput({name, " ready reached"}, int'(ready), 1);
  endtask

  // Presents one request (or a dr+wr pair) and records busy time per accept.
  task automatic applyStimulus(input logic dr_v, input logic wr_v,
                               input logic [7:0] dv, input logic [7:0] wv);
    int n;
    int acc;
    waitReady("pre-request", n);
    @(negedge clk_20m);
    dr    = dr_v;
    wr    = wr_v;
    direc = dv;
    dbi   = wv;
    acc   = int'(dr_v) + int'(wr_v);
    for (int a = 0; a < acc; a++) begin
      @(posedge clk_20m);
      #1;
      if (a == 0 && acc == 2) begin
        dr = 1'b0;
      end else begin
        dr = 1'b0;
        wr = 1'b0;
      end
      waitReady("busy", n);
      busy_q.push_back(n);
    end
  endtask

  task automatic checkTransfer(input string name, input logic rs_e,
                               input logic [7:0] db_e, input int busy_e);
    strobe_t s;
    int      b;
    checkOutput({name, " strobe seen"}, int'(strobes.size() > 0), 1);
    if (strobes.size() > 0) begin
      s = strobes.pop_front();
      checkOutput({name, " rs"}, int'(s.rs), int'(rs_e));
      checkOutput({name, " db"}, int'(s.db), int'(db_e));
    end
    checkOutput({name, " busy recorded"}, int'(busy_q.size() > 0), 1);
    if (busy_q.size() > 0) begin
      b = busy_q.pop_front();
      checkOutput({name, " busy cycles"}, b, busy_e);
    end
  endtask

  // Reference: every transfer costs setup+enable+hold plus the execution
  // wait, which is the long one only for instruction bytes 0x01..0x03.
  function automatic int modelBusy(input logic rs, input logic [7:0] b);
    int w;
    w = (!rs && b >= 8'h01 && b <= 8'h03) ? C : X;
    return BASE + w;
  endfunction

  task automatic checkInit(input int last_rst_cyc);
    logic [7:0] rom[6];
    int         n;
    int         early;
    strobe_t    s;
    rom   = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    n     = 0;
    early = 0;
    while (!ready && n < TIMEOUT) begin
      @(posedge clk_20m);
      #1;
      n++;
      if (!ready && init_done) early++;
    end
    checkOutput("init ready", int'(ready), 1);
    checkOutput("init_done set", int'(init_done), 1);
    checkOutput("init_done early", early, 0);
    checkOutput("powerup not short", int'(first_rise_cyc - last_rst_cyc >= P), 1);
    checkOutput("powerup not long", int'(first_rise_cyc - last_rst_cyc <= P + S + 2), 1);
    checkOutput("clear gap", cyc - fall_cyc, H + C);
    checkOutput("init strobe count", strobes.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (strobes.size() > 0) begin
        s = strobes.pop_front();
        checkOutput($sformatf("init[%0d] rs", i), int'(s.rs), 0);
        checkOutput($sformatf("init[%0d] db", i), int'(s.db), int'(rom[i]));
      end
    end
    strobes.delete();
    busy_q.delete();
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " ready"}, int'(ready), 0);
    checkOutput({name, " init_done"}, int'(init_done), 0);
    checkOutput({name, " lcd_e"}, int'(lcd_e), 0);
    checkOutput({name, " lcd_rs"}, int'(lcd_rs), 0);
    checkOutput({name, " lcd_rw"}, int'(lcd_rw), 0);
    checkOutput({name, " lcd_db"}, int'(lcd_db), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[8];
    strobe_t    exp_q[$];
    strobe_t    ex;
    int         n;
    int         kind;
    logic [7:0] dv, wv;
    int         last_rst;

    vecs[0] = '{"data E",     1'b0, 1'b1, 8'h00, 8'h45, 1'b1, 8'h45, BASE + X};
    vecs[1] = '{"ddram 0x86", 1'b1, 1'b0, 8'h86, 8'h00, 1'b0, 8'h86, BASE + X};
    vecs[2] = '{"clear",      1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h01, BASE + C};
    vecs[3] = '{"home 02",    1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h02, BASE + C};
    vecs[4] = '{"home 03",    1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h03, BASE + C};
    vecs[5] = '{"instr 04",   1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h04, BASE + X};
    vecs[6] = '{"data 01",    1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 8'h01, BASE + X};
    vecs[7] = '{"instr 00",   1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, BASE + X};

    $display("[TB] power-on reset");
    repeat (3) @(negedge clk_20m);
    checkResetOutputs("reset");
    rst            = 1'b1;
    last_rst       = cyc;
    first_rise_cyc = -1;
    checkInit(last_rst);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dr, vecs[i].wr, vecs[i].direc, vecs[i].dbi);
      checkTransfer(vecs[i].name, vecs[i].exp_rs, vecs[i].exp_db, vecs[i].exp_busy);
    end
    checkOutput("db held in idle", int'(lcd_db), 8'h00);

    $display("[TB] simultaneous dr and wr");
    applyStimulus(1'b1, 1'b1, 8'h95, 8'h73);
    checkTransfer("both instr", 1'b0, 8'h95, BASE + X);
    checkTransfer("both data", 1'b1, 8'h73, BASE + X);
    checkOutput("db held after pair", int'(lcd_db), 8'h73);

    $display("[TB] randomized requests");
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 2));
      dv   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      wv   = 8'($urandom);
      if (kind != 1) begin
        ex.rs = 1'b0;
        ex.db = dv;
        exp_q.push_back(ex);
      end
      if (kind != 0) begin
        ex.rs = 1'b1;
        ex.db = wv;
        exp_q.push_back(ex);
      end
      applyStimulus(kind != 1, kind != 0, dv, wv);
      while (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checkTransfer($sformatf("rand%0d", t), ex.rs, ex.db, modelBusy(ex.rs, ex.db));
      end
    end

    $display("[TB] reset during enable");
    waitReady("pre-abort", n);
    @(negedge clk_20m);
    wr  = 1'b1;
    dbi = 8'h5A;
    @(posedge clk_20m);
    #1;
    wr = 1'b0;
    n  = 0;
    while (!lcd_e && n < TIMEOUT) begin
      @(negedge clk_20m);
      n++;
    end
    checkOutput("abort reached enable", int'(lcd_e), 1);
    rst = 1'b0;
    @(posedge clk_20m);
    #1;
    checkResetOutputs("abort");
    repeat (2) @(negedge clk_20m);
    strobes.delete();
    busy_q.delete();
    rst            = 1'b1;
    last_rst       = cyc;
    first_rise_cyc = -1;
    checkInit(last_rst);

    applyStimulus(1'b0, 1'b1, 8'h00, 8'h41);
    checkTransfer("post-reset data", 1'b1, 8'h41, BASE + X);

    checkOutput("lcd_rw always 0", rw_errors, 0);
    checkOutput("bus stable during E", glitch_errors, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
